phase_sequencer: RTL and testbench



---
 rtl/phase_sequencer.sv | 131 +++++++++++++
 tb/tb_phase_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Multi-channel phase generator: period (us) -> phase step via a sequential divider,
// one shared accumulator, per-channel offsets. Optional sync input under PHASE_SYNC_EN.
module phase_sequencer #(
    parameter int PHASE_W     = 13,
    parameter int FRAC_W      = 8,
    parameter int PERIOD_W    = 8,
    parameter int CLKS_PER_US = 10,
    parameter int NUM_CH      = 2
) (
    input  logic                        clock,
    input  logic                        reset,
`ifdef PHASE_SYNC_EN
    input  logic                        sync_in,
`endif
    input  logic [PERIOD_W-1:0]         period,
    input  logic                        period_valid,
    output logic                        period_ready,
    input  logic [NUM_CH*PHASE_W-1:0]   ch_offset,
    output logic [NUM_CH*PHASE_W-1:0]   phase_out,
    output logic                        wrap,
    output logic                        running
);

    localparam int ACC_W = PHASE_W + FRAC_W;
    localparam int T_W   = PERIOD_W + $clog2(CLKS_PER_US + 1);
    localparam int CNT_W = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ACC_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] step;
    logic [ACC_W-1:0] quo;
    logic [ACC_W-1:0] step_next;
    logic [ACC_W:0]   acc_sum;
    logic [T_W-1:0]   t_req;
    logic [T_W-1:0]   t_lat;
    logic [T_W-1:0]   rem;
    logic [T_W-1:0]   rem_next;
    logic [T_W:0]     rem_shift;
    logic             rem_ge;
    logic [CNT_W-1:0] bit_cnt;
    logic             carry;
    logic             wrap_d;
    logic             sync_clear;
    logic             apply_step;

`ifdef PHASE_SYNC_EN
    logic sync_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_prev <= 1'b0;
        else        sync_prev <= sync_in;
    end

    assign sync_clear = sync_in & ~sync_prev;
`else
    assign sync_clear = 1'b0;
`endif

    assign t_req      = T_W'(period) * T_W'(CLKS_PER_US);
    assign rem_shift  = {rem, 1'b0};
    assign rem_ge     = rem_shift >= {1'b0, t_lat};
    assign rem_next   = rem_ge ? T_W'(rem_shift - {1'b0, t_lat}) : rem_shift[T_W-1:0];

    // A sync clear discards the increment, so it also suppresses the carry.
    assign acc_sum    = {1'b0, acc} + {1'b0, step};
    assign carry      = acc_sum[ACC_W] & ~sync_clear;
    assign apply_step = (state == ST_PEND) && ((step == '0) || carry);
    assign step_next  = apply_step ? quo : step;

    assign period_ready = (state == ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            step      <= '0;
            running   <= 1'b0;
            wrap_d    <= 1'b0;
            wrap      <= 1'b0;
            phase_out <= '0;
        end else begin
            acc     <= sync_clear ? '0 : acc_sum[ACC_W-1:0];
            step    <= step_next;
            running <= (step_next != '0);
            wrap_d  <= carry;
            wrap    <= wrap_d;
            for (int k = 0; k < NUM_CH; k++) begin
                phase_out[k*PHASE_W +: PHASE_W] <= acc[ACC_W-1:FRAC_W] + ch_offset[k*PHASE_W +: PHASE_W];
            end
        end
    end

    // Restoring division of 2^ACC_W by T: the leading 1 is preloaded into the
    // remainder, so ACC_W iterations suffice and T==1 saturates naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            t_lat   <= '0;
            rem     <= '0;
            quo     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (period_valid) begin
                        t_lat   <= t_req;
                        rem     <= T_W'(1);
                        quo     <= '0;
                        bit_cnt <= '0;
                        state   <= (t_req == '0) ? ST_PEND : ST_DIV;
                    end
                end
                ST_DIV: begin
                    rem     <= rem_next;
                    quo     <= {quo[ACC_W-2:0], rem_ge};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) state <= ST_PEND;
                end
                ST_PEND: begin
                    if (apply_step) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: a cycle-level reference model pushes expected
// outputs each edge, a monitor pops and compares on the falling edge.
module tb_phase_sequencer;

    localparam int PHASE_W     = 13;
    localparam int FRAC_W      = 8;
    localparam int PERIOD_W    = 8;
    localparam int CLKS_PER_US = 10;
    localparam int NUM_CH      = 2;
    localparam int ACC_W       = PHASE_W + FRAC_W;
    localparam longint ACC_MOD = 64'd1 << ACC_W;
    localparam longint PH_MOD  = 64'd1 << PHASE_W;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [PERIOD_W-1:0]       period = '0;
    logic                      period_valid = 1'b0;
    logic                      period_ready;
    logic [NUM_CH*PHASE_W-1:0] ch_offset = '0;
    logic [NUM_CH*PHASE_W-1:0] phase_out;
    logic                      wrap;
    logic                      running;

    logic [PERIOD_W-1:0]       period1 = '0;
    logic                      valid1 = 1'b0;
    logic                      ready1;
    logic [NUM_CH*PHASE_W-1:0] offset1 = '0;
    logic [NUM_CH*PHASE_W-1:0] phase1;
    logic                      wrap1;
    logic                      running1;

    int checks = 0;
    int failures = 0;
    bit rand_offsets = 1'b0;

    phase_sequencer #(
        .PHASE_W(PHASE_W), .FRAC_W(FRAC_W), .PERIOD_W(PERIOD_W),
        .CLKS_PER_US(CLKS_PER_US), .NUM_CH(NUM_CH)
    ) dut (
        .clock(clock), .reset(reset), .period(period), .period_valid(period_valid),
        .period_ready(period_ready), .ch_offset(ch_offset), .phase_out(phase_out),
        .wrap(wrap), .running(running)
    );

    phase_sequencer #(
        .PHASE_W(PHASE_W), .FRAC_W(FRAC_W), .PERIOD_W(PERIOD_W),
        .CLKS_PER_US(1), .NUM_CH(NUM_CH)
    ) dut1 (
        .clock(clock), .reset(reset), .period(period1), .period_valid(valid1),
        .period_ready(ready1), .ch_offset(offset1), .phase_out(phase1),
        .wrap(wrap1), .running(running1)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NUM_CH*PHASE_W-1:0] phase;
        logic                      wrap;
        logic                      running;
        logic                      ready;
    } exp_t;

    exp_t sb[$];

    function automatic void checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic void reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s timed out at %0t", name, $time);
    endfunction

    // Reference model: step = floor(2^ACC_W/T) saturated, usable 22 edges after
    // acceptance (1 for T==0), taken when the old step is zero or on an overflow.
    longint m_acc, m_step, m_new_step, m_edge, m_earliest, m_sum, m_ph;
    bit     m_pending, m_carry_prev, m_carry, m_ready_before;
    longint m_t;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_acc = 0; m_step = 0; m_new_step = 0; m_edge = 0; m_earliest = 0;
            m_pending = 1'b0; m_carry_prev = 1'b0;
            sb.delete();
        end else begin
            exp_t e;
            for (int k = 0; k < NUM_CH; k++) begin
                m_ph = ((m_acc >> FRAC_W) + longint'(ch_offset[k*PHASE_W +: PHASE_W])) % PH_MOD;
                e.phase[k*PHASE_W +: PHASE_W] = PHASE_W'(m_ph);
            end
            e.wrap = m_carry_prev;
            m_ready_before = !m_pending;
            m_sum = m_acc + m_step;
            m_carry = (m_sum >= ACC_MOD);
            if (m_pending && m_edge >= m_earliest && (m_step == 0 || m_carry)) begin
                m_step = m_new_step;
                m_pending = 1'b0;
            end
            m_acc = m_sum % ACC_MOD;
            m_carry_prev = m_carry;
            if (m_ready_before && period_valid) begin
                m_t = longint'(period) * CLKS_PER_US;
                if (m_t == 0) m_new_step = 0;
                else begin
                    m_new_step = ACC_MOD / m_t;
                    if (m_new_step > ACC_MOD - 1) m_new_step = ACC_MOD - 1;
                end
                m_pending = 1'b1;
                m_earliest = m_edge + ((m_t == 0) ? 1 : ACC_W + 1);
            end
            e.running = (m_step != 0);
            e.ready = !m_pending;
            sb.push_back(e);
            m_edge++;
        end
    end

    // Monitor: compares every presented cycle against the oldest expectation.
    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("rst_phase_out", phase_out, 0);
            checkOutput("rst_wrap", wrap, 0);
            checkOutput("rst_running", running, 0);
            checkOutput("rst_ready", period_ready, 1);
        end else if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("phase_out", phase_out, e.phase);
            checkOutput("wrap", wrap, e.wrap);
            checkOutput("running", running, e.running);
            checkOutput("period_ready", period_ready, e.ready);
        end
    end

    always @(negedge clock) begin
        if (rand_offsets) begin
            for (int k = 0; k < NUM_CH; k++) ch_offset[k*PHASE_W +: PHASE_W] = PHASE_W'($urandom);
        end
    end

    task automatic applyStimulus(input int p);
        bit ok;
        ok = 1'b0;
        period = PERIOD_W'(p);
        period_valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (period_ready) ok = 1'b1;
            @(posedge clock);
            if (ok) break;
            @(negedge clock);
        end
        @(negedge clock);
        period_valid = 1'b0;
        if (!ok) reportTimeout("handshake");
    endtask

    task automatic waitReady(input int bound, output int n);
        n = 0;
        while (!period_ready && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (!period_ready) reportTimeout("wait_ready");
    endtask

    initial begin
        int n;
        int wraps;
        logic [PHASE_W-1:0] diff;

        ch_offset[0 +: PHASE_W] = PHASE_W'(0);
        ch_offset[PHASE_W +: PHASE_W] = PHASE_W'(2048);
        repeat (3) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);

        // Saturation case on the CLKS_PER_US=1 instance.
        checkOutput("dut1_ready", ready1, 1);
        period1 = PERIOD_W'(1);
        valid1 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        valid1 = 1'b0;
        repeat (60) @(negedge clock);
        checkOutput("dut1_running", running1, 1);
        checkOutput("dut1_phase_sat", phase1[0 +: PHASE_W], 8191);
        checkOutput("dut1_wrap_sat", wrap1, 1);

        // period=8 from idle: ready timing, first increment and first wrap.
        applyStimulus(8);
        waitReady(100, n);
        checkOutput("ready_low_cycles", n, 22);
        @(negedge clock);
        @(negedge clock);
        checkOutput("first_phase", phase_out[0 +: PHASE_W], 102);
        checkOutput("running_after_load", running, 1);
        diff = phase_out[PHASE_W +: PHASE_W] - phase_out[0 +: PHASE_W];
        checkOutput("quadrature_diff", diff, 2048);
        n = 2;
        while (!wrap && n < 300) begin
            @(negedge clock);
            n++;
        end
        checkOutput("first_wrap_cycle", n, 82);
        diff = phase_out[PHASE_W +: PHASE_W] - phase_out[0 +: PHASE_W];
        checkOutput("quadrature_diff_wrap", diff, 2048);

        // Period change while running takes effect at the next overflow.
        applyStimulus(13);
        waitReady(2000, n);
        @(negedge clock);
        checkOutput("update_on_wrap", wrap, 1);

        // Request held during division is accepted exactly once.
        applyStimulus(8);
        applyStimulus(4);
        checkOutput("busy_after_hold", period_ready, 0);
        waitReady(2000, n);

        // Zero period halts at the next wrap.
        applyStimulus(0);
        waitReady(2000, n);
        checkOutput("halt_running", running, 0);
        @(negedge clock);
        checkOutput("halt_last_wrap", wrap, 1);
        wraps = 0;
        repeat (40) begin
            @(negedge clock);
            if (wrap) wraps++;
        end
        checkOutput("no_wrap_after_halt", wraps, 0);

        // Reset during division aborts it.
        applyStimulus(8);
        repeat (9) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_ready", period_ready, 1);
        checkOutput("abort_running", running, 0);
        checkOutput("abort_phase", phase_out, 0);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        checkOutput("restart_ready", period_ready, 1);

        // Randomized requests with randomized offsets.
        rand_offsets = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(int'($urandom_range(0, 2)));
            else applyStimulus(int'($urandom_range(3, 25)));
            repeat ($urandom_range(0, 30)) @(negedge clock);
        end
        waitReady(4000, n);
        repeat (20) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
